// File: rtl/ahb2apb_bridge_pkg.sv
// Shared types and address-map constants for the AHB-Lite to APB bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_SETUP,
        ST_ACCESS
    } bridge_state_t;

    // Peripheral window: top nibble selects the APB segment, next two bits pick the peripheral.
    localparam logic [3:0] REGION_NIBBLE = 4'h8;
    localparam int         REGION_MSB    = 31;
    localparam int         REGION_LSB    = 28;
    localparam int         IDX_MSB       = 27;
    localparam int         IDX_LSB       = 26;

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// Bundles the AHB-Lite slave side and APB master side of the bridge.
// Latency: n/a (wires only).
// Backpressure: HREADY_OUT carries bridge wait states back to the AHB master.
// Modports: slave = bridge view (AHB slave, APB master); master = fabric/peripheral view.
interface ahb2apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [1:0]            HTRANS;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic                  HREADY_IN;
    logic                  HREADY_OUT;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic [1:0]            HRESP;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;

    modport slave (
        input  HADDR, HWRITE, HTRANS, HWDATA, HSIZE, HBURST, HREADY_IN, PRDATA,
        output HREADY_OUT, HRDATA, HRESP, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport master (
        output HADDR, HWRITE, HTRANS, HWDATA, HSIZE, HBURST, HREADY_IN, PRDATA,
        input  HREADY_OUT, HRDATA, HRESP, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ahb2apb_bridge_decode.sv
// Combinational AHB address decode: range check, transfer-valid and one-hot peripheral select.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller qualifies valid with its own ready.
// Ports: haddr/htrans/hready_in in; in_range, valid, sel_onehot out.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hready_in,
    output logic                  in_range,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] sel_onehot
);
    logic [1:0] idx;
    logic       unused_addr;

    // Low address bits only matter to the peripheral, not to the decode.
    assign unused_addr = ^{haddr[IDX_LSB-1:0], htrans[0]};

    always_comb begin
        idx      = haddr[IDX_MSB:IDX_LSB];
        in_range = (haddr[REGION_MSB:REGION_LSB] == REGION_NIBBLE) &&
                   ({1'b0, idx} < 3'(NUM_SLAVES));
        // NONSEQ and SEQ both have bit 1 set; IDLE/BUSY never start a transfer.
        valid    = hready_in && htrans[1] && in_range;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (idx == 2'(i));
        end
    end
endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge; one outstanding transfer, full SETUP/ACCESS per beat.
// Latency: read completes 3 edges after address sample, write 4 (data phase included).
// Backpressure: HREADY_OUT low while an APB transfer is in flight; new addresses ignored then.
// Ports: CLK, HRESET (sync, active-high); bus = AHB slave + APB master signals.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic            CLK,
    input  logic            HRESET,
    ahb2apb_bridge_if.slave bus
);
    bridge_state_t         state_q, state_d;
    logic                  hready_out_q, hready_out_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [NUM_SLAVES-1:0] sel_lat_q, sel_lat_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

    logic                  dec_in_range;
    logic                  dec_valid;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  unused_ctrl;

    // Transfer size and burst type do not change how a beat is carried.
    assign unused_ctrl = ^{bus.HSIZE, bus.HBURST, dec_in_range};

    ahb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .haddr      (bus.HADDR),
        .htrans     (bus.HTRANS),
        .hready_in  (bus.HREADY_IN),
        .in_range   (dec_in_range),
        .valid      (dec_valid),
        .sel_onehot (dec_sel)
    );

    always_comb begin
        state_d      = state_q;
        hready_out_d = hready_out_q;
        hrdata_d     = hrdata_q;
        psel_d       = psel_q;
        sel_lat_d    = sel_lat_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dec_valid && hready_out_q) begin
                    paddr_d      = bus.HADDR;
                    pwrite_d     = bus.HWRITE;
                    sel_lat_d    = dec_sel;
                    hready_out_d = 1'b0;
                    if (bus.HWRITE) begin
                        // Write data arrives one cycle later, in the AHB data phase.
                        state_d = ST_WWAIT;
                    end else begin
                        state_d = ST_SETUP;
                        psel_d  = dec_sel;
                    end
                end
            end
            ST_WWAIT: begin
                pwdata_d = bus.HWDATA;
                psel_d   = sel_lat_q;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!pwrite_q) begin
                    hrdata_d = bus.PRDATA;
                end
                psel_d       = '0;
                penable_d    = 1'b0;
                hready_out_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            hready_out_q <= 1'b1;
            hrdata_q     <= '0;
            psel_q       <= '0;
            sel_lat_q    <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            hready_out_q <= hready_out_d;
            hrdata_q     <= hrdata_d;
            psel_q       <= psel_d;
            sel_lat_q    <= sel_lat_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
        end
    end

    assign bus.HREADY_OUT = hready_out_q;
    assign bus.HRDATA     = hrdata_q;
    assign bus.HRESP      = HRESP_OKAY;
    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge with APB and read-data scoreboards.
// Latency: checks 3-edge reads and 4-edge writes from address sample to completion.
// Backpressure: drives a new address only at a cycle where HREADY_OUT is high.
module tb_ahb2apb_bridge;
    import ahb_apb_pkg::*;

    logic CLK = 1'b0;
    logic HRESET;

    ahb2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) bus ();

    ahb2apb_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SLAVES (3)
    ) dut (
        .CLK    (CLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_t;

    apb_t        apb_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad = 0;
    int          access_cnt = 0;
    int          psel_cnt = 0;
    logic        prev_hready = 1'b1;
    logic        last_rd = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] sel_of(input logic [31:0] addr);
        logic [2:0] one;
        one = 3'b001;
        return one << addr[27:26];
    endfunction

    // Advance to the next falling edge and run the output monitors there.
    task automatic tick();
        apb_t e;
        @(negedge CLK);
        if (|bus.PSEL) psel_cnt++;
        if (|bus.PSEL && bus.PENABLE) begin
            access_cnt++;
            chk("apb_expected", 32'(apb_q.size() > 0), 32'd1);
            if (apb_q.size() > 0) begin
                e = apb_q.pop_front();
                chk("apb_psel",   32'(bus.PSEL),   32'(e.sel));
                chk("apb_pwrite", 32'(bus.PWRITE), 32'(e.wr));
                chk("apb_paddr",  bus.PADDR,       e.addr);
                if (e.wr) chk("apb_pwdata", bus.PWDATA, e.wdata);
            end
        end
        if (bus.HREADY_OUT && !prev_hready && last_rd) begin
            chk("rd_expected", 32'(rd_q.size()), 32'd1);
            if (rd_q.size() > 0) begin
                last_rdata = rd_q.pop_front();
                chk("hrdata", bus.HRDATA, last_rdata);
            end
        end
        prev_hready = bus.HREADY_OUT;
    endtask

    // Called at a falling edge with HREADY_OUT high; returns at the falling edge
    // where HREADY_OUT is high again, so the next call is back-to-back.
    task automatic ahb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] prdata,
                            input logic [1:0] trans, input logic [2:0] burst,
                            input logic exp_valid);
        int n;
        int acc0;
        int psel0;
        acc0  = access_cnt;
        psel0 = psel_cnt;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HTRANS = trans;
        bus.HBURST = burst;
        bus.HSIZE  = 3'b010;
        bus.PRDATA = prdata;
        if (exp_valid) begin
            apb_q.push_back('{sel: sel_of(addr), wr: wr, addr: addr, wdata: wdata});
            if (!wr) rd_q.push_back(prdata);
            last_rd = !wr;
        end
        tick();
        // Data phase: write data now; address-phase noise must be ignored while waiting.
        bus.HWDATA = wdata;
        bus.HADDR  = 32'h8800_0040;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = 1'b0;
        n = 1;
        while (!bus.HREADY_OUT && n < 12) begin
            tick();
            n++;
            if (n == 2) bus.HWDATA = ~wdata;
        end
        bus.HTRANS = HTRANS_IDLE;
        chk({tag, "_len"}, 32'(n), exp_valid ? (wr ? 32'd4 : 32'd3) : 32'd1);
        chk({tag, "_accesses"}, 32'(access_cnt - acc0), exp_valid ? 32'd1 : 32'd0);
        chk({tag, "_psel_cycles"}, 32'(psel_cnt - psel0), exp_valid ? 32'd2 : 32'd0);
        chk({tag, "_hresp"}, 32'(bus.HRESP), 32'(HRESP_OKAY));
        chk({tag, "_psel_idle"}, 32'(bus.PSEL), 32'd0);
        if (exp_valid) begin
            chk({tag, "_paddr_hold"}, bus.PADDR, addr);
            chk({tag, "_pwrite_hold"}, 32'(bus.PWRITE), 32'(wr));
        end else begin
            chk({tag, "_hrdata_kept"}, bus.HRDATA, last_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        HRESET        = 1'b1;
        bus.HADDR     = '0;
        bus.HWRITE    = 1'b0;
        bus.HTRANS    = HTRANS_IDLE;
        bus.HWDATA    = '0;
        bus.HSIZE     = 3'b010;
        bus.HBURST    = 3'b000;
        bus.HREADY_IN = 1'b1;
        bus.PRDATA    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_hready", 32'(bus.HREADY_OUT), 32'd1);
        chk("rst_psel",   32'(bus.PSEL),       32'd0);
        chk("rst_penable",32'(bus.PENABLE),    32'd0);
        chk("rst_hrdata", bus.HRDATA,          32'd0);
        chk("rst_hresp",  32'(bus.HRESP),      32'd0);
        chk("rst_paddr",  bus.PADDR,           32'd0);
        chk("rst_pwdata", bus.PWDATA,          32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE),     32'd0);
        HRESET = 1'b0;
        tick();

        // Single write and single read
        ahb_xfer("wr0", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, HTRANS_NONSEQ, 3'b000, 1'b1);
        chk("wr0_pwdata_hold", bus.PWDATA, 32'hDEAD_BEEF);
        ahb_xfer("rd0", 1'b0, 32'h8400_0004, 32'h0, 32'h1234_5678, HTRANS_NONSEQ, 3'b000, 1'b1);

        // Ignored transfers
        ahb_xfer("ign_idle", 1'b1, 32'h8000_0000, 32'h1111_1111, 32'h0, HTRANS_IDLE,   3'b000, 1'b0);
        ahb_xfer("ign_busy", 1'b0, 32'h8400_0000, 32'h0, 32'h2222_2222, HTRANS_BUSY,   3'b000, 1'b0);
        ahb_xfer("ign_low",  1'b1, 32'h1000_0000, 32'h3333_3333, 32'h0, HTRANS_NONSEQ, 3'b000, 1'b0);
        ahb_xfer("ign_slv3", 1'b0, 32'h8C00_0000, 32'h0, 32'h4444_4444, HTRANS_NONSEQ, 3'b000, 1'b0);
        chk("ign_pwdata_kept", bus.PWDATA, 32'hDEAD_BEEF);
        bus.HREADY_IN = 1'b0;
        ahb_xfer("ign_hrdyin", 1'b1, 32'h8000_0000, 32'h5555_5555, 32'h0, HTRANS_NONSEQ, 3'b000, 1'b0);
        bus.HREADY_IN = 1'b1;

        // INCR4 write burst, back-to-back beats
        for (int b = 0; b < 4; b++) begin
            ahb_xfer("burst", 1'b1, 32'h8800_0000 + 32'(4 * b), 32'hA5A5_0000 + 32'(b),
                     32'h0, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 3'b011, 1'b1);
        end

        // Reset during ACCESS of a write
        bus.HADDR  = 32'h8000_0020;
        bus.HWRITE = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        apb_q.push_back('{sel: 3'b001, wr: 1'b1, addr: 32'h8000_0020, wdata: 32'hBAD0_0001});
        last_rd = 1'b0;
        tick();
        bus.HTRANS = HTRANS_IDLE;
        bus.HWDATA = 32'hBAD0_0001;
        tick();
        tick();
        chk("mid_in_access", 32'(bus.PENABLE), 32'd1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("mid_psel",    32'(bus.PSEL),       32'd0);
        chk("mid_penable", 32'(bus.PENABLE),    32'd0);
        chk("mid_hready",  32'(bus.HREADY_OUT), 32'd1);
        chk("mid_paddr",   bus.PADDR,           32'd0);
        chk("mid_pwdata",  bus.PWDATA,          32'd0);
        chk("mid_hrdata",  bus.HRDATA,          32'd0);
        last_rdata = 32'h0;
        tick();
        ahb_xfer("rd1", 1'b0, 32'h8400_0008, 32'h0, 32'hCAFE_F00D, HTRANS_NONSEQ, 3'b000, 1'b1);
        tick();
        tick();

        chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
        chk("rd_q_drained",  32'(rd_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
